// File: rtl/mul.sv
// -----------------------------------------------------------------------------
// mul -- registered rational-number multiplier
//
// Computes (l_num/l_den) * (r_num/r_den) = (s_num/s_den) by multiplying the
// numerators and the denominators independently. There is no gcd reduction,
// no sign handling and no normalisation. Products are unsigned and wrap
// modulo 2^WIDTH. The block has a latency of one cycle and accepts new
// operands every cycle.
//
// Optional build macro: MUL_OVF_EN
//   When defined, adds the registered output 'ovf'. It is set when the
//   upper WIDTH bits of either full product are nonzero.
//
// Parameters:
//   WIDTH     bit width of every numerator/denominator (2..64)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (clears all outputs)
//   l_num     left operand numerator
//   l_den     left operand denominator
//   r_num     right operand numerator
//   r_den     right operand denominator
//   s_num     registered product numerator   (l_num*r_num mod 2^WIDTH)
//   s_den     registered product denominator (l_den*r_den mod 2^WIDTH)
//   den_zero  registered flag, s_den == 0
//   ovf       (MUL_OVF_EN only) registered product-overflow flag
// -----------------------------------------------------------------------------
module mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] l_num,
  input  logic [WIDTH-1:0] l_den,
  input  logic [WIDTH-1:0] r_num,
  input  logic [WIDTH-1:0] r_den,
  output logic [WIDTH-1:0] s_num,
  output logic [WIDTH-1:0] s_den,
`ifdef MUL_OVF_EN
  output logic             ovf,
`endif
  output logic             den_zero
);

  logic [WIDTH-1:0] r_s_num;
  logic [WIDTH-1:0] r_s_den;
  logic             r_den_zero;

  logic [WIDTH-1:0] w_num_lo;
  logic [WIDTH-1:0] w_den_lo;

`ifdef MUL_OVF_EN
  // The full double-width products are needed only to see the discarded
  // upper halves for the overflow flag.
  logic [2*WIDTH-1:0] w_num_full;
  logic [2*WIDTH-1:0] w_den_full;
  logic               w_ovf;
  logic               r_ovf;

  assign w_num_full = {{WIDTH{1'b0}}, l_num} * {{WIDTH{1'b0}}, r_num};
  assign w_den_full = {{WIDTH{1'b0}}, l_den} * {{WIDTH{1'b0}}, r_den};
  assign w_num_lo   = w_num_full[WIDTH-1:0];
  assign w_den_lo   = w_den_full[WIDTH-1:0];
  assign w_ovf      = (|w_num_full[2*WIDTH-1:WIDTH]) |
                      (|w_den_full[2*WIDTH-1:WIDTH]);
`else
  // A WIDTH-wide product keeps only the low half. That is exactly the
  // wrap-around result, and the upper half is never built.
  assign w_num_lo = l_num * r_num;
  assign w_den_lo = l_den * r_den;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_num    <= '0;
      r_s_den    <= '0;
      r_den_zero <= 1'b0;
    end else begin
      r_s_num    <= w_num_lo;
      r_s_den    <= w_den_lo;
      // The flag uses the truncated denominator, so it always agrees with s_den.
      r_den_zero <= (w_den_lo == '0);
    end
  end

`ifdef MUL_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

  assign s_num    = r_s_num;
  assign s_den    = r_s_den;
  assign den_zero = r_den_zero;

endmodule

// File: tb/tb_mul.sv
// -----------------------------------------------------------------------------
// tb_mul -- self-checking testbench for mul (WIDTH = 32)
//
// Each scenario task applies inputs just after a rising edge. It then waits
// for the next rising edge and compares the outputs 1 time unit later.
// Define MUL_OVF_EN here as well when building the DUT with that macro.
// -----------------------------------------------------------------------------
module tb_mul;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] l_num, l_den, r_num, r_den;
  logic [W-1:0] s_num, s_den;
  logic         den_zero;
`ifdef MUL_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  mul #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .l_num    (l_num),
    .l_den    (l_den),
    .r_num    (r_num),
    .r_den    (r_den),
    .s_num    (s_num),
    .s_den    (s_den),
`ifdef MUL_OVF_EN
    .ovf      (ovf),
`endif
    .den_zero (den_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [W-1:0] ln, input logic [W-1:0] ld,
                         input logic [W-1:0] rn, input logic [W-1:0] rd);
    l_num = ln; l_den = ld; r_num = rn; r_den = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_ops(5, 7, 3, 2);
    tick();
    tick();
    checks++;
    if (s_num !== 0) begin
      failures++;
      $display("FAIL reset_s_num got=%0d exp=0", s_num);
    end
    checks++;
    if (s_den !== 0) begin
      failures++;
      $display("FAIL reset_s_den got=%0d exp=0", s_den);
    end
    checks++;
    if (den_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_den_zero got=%0b exp=0", den_zero);
    end
`ifdef MUL_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf got=%0b exp=0", ovf);
    end
`endif
    $display("reset: s_num=%0d s_den=%0d den_zero=%0b", s_num, s_den, den_zero);
    rst = 1'b0;
    tick();
    checks++;
    if (s_num !== 15 || s_den !== 14) begin
      failures++;
      $display("FAIL reset_release got=%0d/%0d exp=15/14", s_num, s_den);
    end
    $display("release: 5/7 * 3/2 -> %0d/%0d", s_num, s_den);
  endtask

  task automatic test_basic();
    logic [63:0] en, ed;
    set_ops(999, 998, 997, 996);
    tick();
    checks++;
    if (s_num !== 996003 || s_den !== 994008 || den_zero !== 1'b0) begin
      failures++;
      $display("FAIL basic_999 got=%0d/%0d dz=%0b exp=996003/994008 dz=0",
               s_num, s_den, den_zero);
    end
    $display("basic: 999/998 * 997/996 -> %0d/%0d", s_num, s_den);
    for (int i = 0; i < 20; i++) begin
      set_ops($urandom_range(999, 0), $urandom_range(999, 0),
              $urandom_range(999, 0), $urandom_range(999, 0));
      en = 64'(l_num) * 64'(r_num);
      ed = 64'(l_den) * 64'(r_den);
      tick();
      checks++;
      if (s_num !== en[W-1:0] || s_den !== ed[W-1:0] ||
          den_zero !== (ed == 0)) begin
        failures++;
        $display("FAIL basic_rand%0d got=%0d/%0d dz=%0b exp=%0d/%0d dz=%0b",
                 i, s_num, s_den, den_zero, en, ed, (ed == 0));
      end
      $display("rand%0d: %0d/%0d * %0d/%0d -> %0d/%0d dz=%0b",
               i, l_num, l_den, r_num, r_den, s_num, s_den, den_zero);
    end
  endtask

  task automatic test_zero_den();
    set_ops(4, 0, 6, 123);
    tick();
    checks++;
    if (s_num !== 24 || s_den !== 0 || den_zero !== 1'b1) begin
      failures++;
      $display("FAIL zero_den got=%0d/%0d dz=%0b exp=24/0 dz=1", s_num, s_den, den_zero);
    end
    $display("zero_den: 4/0 * 6/123 -> %0d/%0d dz=%0b", s_num, s_den, den_zero);
    set_ops(4, 1, 6, 1);
    tick();
    checks++;
    if (s_num !== 24 || s_den !== 1 || den_zero !== 1'b0) begin
      failures++;
      $display("FAIL den_nonzero got=%0d/%0d dz=%0b exp=24/1 dz=0", s_num, s_den, den_zero);
    end
    $display("den_nonzero: 4/1 * 6/1 -> %0d/%0d dz=%0b", s_num, s_den, den_zero);
  endtask

  task automatic test_wrap();
    set_ops(32'h0001_0000, 1, 32'h0001_0000, 1);
    tick();
    checks++;
    if (s_num !== 0 || s_den !== 1) begin
      failures++;
      $display("FAIL wrap_2p32 got=%h/%h exp=00000000/00000001", s_num, s_den);
    end
`ifdef MUL_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL wrap_2p32_ovf got=%0b exp=1", ovf);
    end
`endif
    $display("wrap: 10000h*10000h -> s_num=%h", s_num);
    set_ops(32'hFFFF_FFFF, 3, 2, 5);
    tick();
    checks++;
    if (s_num !== 32'hFFFF_FFFE || s_den !== 15) begin
      failures++;
      $display("FAIL wrap_ffff got=%h/%0d exp=fffffffe/15", s_num, s_den);
    end
`ifdef MUL_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL wrap_ffff_ovf got=%0b exp=1", ovf);
    end
    // Overflow only in the denominator must also raise the flag.
    set_ops(2, 32'h8000_0000, 3, 2);
    tick();
    checks++;
    if (ovf !== 1'b1 || s_den !== 0 || den_zero !== 1'b1 || s_num !== 6) begin
      failures++;
      $display("FAIL wrap_den_ovf got ovf=%0b %0d/%0d dz=%0b exp ovf=1 6/0 dz=1",
               ovf, s_num, s_den, den_zero);
    end
    set_ops(32'hFFFF, 7, 32'h10001, 9);
    tick();
    checks++;
    if (ovf !== 1'b0 || s_num !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL no_ovf got ovf=%0b s_num=%h exp ovf=0 s_num=ffffffff", ovf, s_num);
    end
`endif
    $display("wrap: ffffffffh*2 -> s_num=%h", s_num);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_n [5] = '{2, 24, 80, 168, 288};
    logic [W-1:0] exp_d [5] = '{3, 35, 99, 195, 323};
    for (int i = 0; i < 5; i++) begin
      set_ops(W'(4*i), W'(4*i+1), W'(4*i+2), W'(4*i+3));
      if (i == 0) l_num = 1;
      tick();
      checks++;
      if (s_num !== exp_n[i] || s_den !== exp_d[i]) begin
        failures++;
        $display("FAIL b2b%0d got=%0d/%0d exp=%0d/%0d", i, s_num, s_den, exp_n[i], exp_d[i]);
      end
      $display("b2b%0d: -> %0d/%0d", i, s_num, s_den);
    end
  endtask

  task automatic test_mid_reset();
    set_ops(3, 4, 5, 6);
    tick();
    checks++;
    if (s_num !== 15 || s_den !== 24) begin
      failures++;
      $display("FAIL midrst_pre got=%0d/%0d exp=15/24", s_num, s_den);
    end
    $display("midrst_pre: -> %0d/%0d", s_num, s_den);
    rst = 1'b1;
    set_ops(7, 8, 9, 10);
    tick();
    checks++;
    if (s_num !== 0 || s_den !== 0 || den_zero !== 1'b0) begin
      failures++;
      $display("FAIL midrst_clear got=%0d/%0d dz=%0b exp=0/0 dz=0", s_num, s_den, den_zero);
    end
    $display("midrst_clear: -> %0d/%0d", s_num, s_den);
    rst = 1'b0;
    tick();
    checks++;
    if (s_num !== 63 || s_den !== 80) begin
      failures++;
      $display("FAIL midrst_resume got=%0d/%0d exp=63/80", s_num, s_den);
    end
    $display("midrst_resume: -> %0d/%0d", s_num, s_den);
  endtask

  initial begin
    rst = 1'b1;
    set_ops(0, 0, 0, 0);
    #2;
    test_reset();
    test_basic();
    test_zero_den();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
